simple_bus: RTL and testbench

Single-clock, multi-host/multi-device memory interconnect for the simple system. It arbitrates requests from NrHosts bus hosts, such as the core data port. It decodes each winning address against per-device base/mask registers and forwards the request to one device. The read/error response returns to the originating host one cycle later.

---
 rtl/bus_pkg.sv | 16 +
 rtl/simple_bus_if.sv | 44 ++++
 rtl/bus_arbiter.sv | 29 ++
 rtl/simple_bus.sv | 151 +++++++++++++++
 tb/tb_simple_bus.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared helpers and constants for the simple_bus interconnect.
// Build option: BUS_DECODE_ERR_EN (see simple_bus.sv).
package bus_pkg;

  // Width of an index selecting one of n items; never narrower than 1 bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Response-register reset values.
  localparam int unsigned RESP_HOST_RST     = 0;
  localparam int unsigned RESP_DEV_RST      = 0;
  localparam logic        RESP_UNMAPPED_RST = 1'b0;
  localparam logic        RESP_VLD_RST      = 1'b0;

endpackage

// File: rtl/simple_bus_if.sv
// Host and device signal bundle for simple_bus.
// The slave modport is the interconnect's view; master is the surrounding system's view.
interface simple_bus_if #(
  parameter int NrHosts      = 1,
  parameter int NrDevices    = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  localparam int BeW = DataWidth / 8;

  logic [NrHosts-1:0]                   host_req_i;
  logic [NrHosts-1:0]                   host_we_i;
  logic [NrHosts-1:0][AddressWidth-1:0] host_addr_i;
  logic [NrHosts-1:0][BeW-1:0]          host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i;
  logic [NrHosts-1:0]                   host_gnt_o;
  logic [NrHosts-1:0]                   host_rvalid_o;
  logic [NrHosts-1:0]                   host_err_o;
  logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o;

  logic [NrDevices-1:0]                   device_req_o;
  logic [NrDevices-1:0]                   device_we_o;
  logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o;
  logic [NrDevices-1:0][BeW-1:0]          device_be_o;
  logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o;
  logic [NrDevices-1:0]                   device_rvalid_i;
  logic [NrDevices-1:0]                   device_err_i;
  logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i;

  modport slave (
    input  host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
    output device_req_o, device_we_o, device_addr_o, device_be_o, device_wdata_o,
    input  device_rvalid_i, device_err_i, device_rdata_i
  );

  modport master (
    output host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
    input  device_req_o, device_we_o, device_addr_o, device_be_o, device_wdata_o,
    output device_rvalid_i, device_err_i, device_rdata_i
  );

endinterface

// File: rtl/bus_arbiter.sv
// Fixed-priority arbiter: lowest-index requester wins, one-hot grant plus encoded index.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NrHosts = 1
) (
  input  logic [NrHosts-1:0]          req,
  output logic [NrHosts-1:0]          gnt,
  output logic [sel_w(NrHosts)-1:0]   idx,
  output logic                        any
);
  localparam int IdxW = sel_w(NrHosts);

  // Scan from the top down so the lowest requesting index is the one left standing.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = NrHosts - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IdxW'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simple_bus.sv
// simple_bus: multi-host / multi-device interconnect with one-cycle response return.
// Build option BUS_DECODE_ERR_EN: unmapped addresses are granted, reach no device,
// and return rvalid=1, err=1, rdata=0; otherwise they fall through to device 0.
module simple_bus
  import bus_pkg::*;
#(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input logic                                 clk_i,
  input logic                                 rst_ni,
  simple_bus_if.slave                         bus,
  input logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base,
  input logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask
);
  localparam int HostSelW = sel_w(NrHosts);
  localparam int DevSelW  = sel_w(NrDevices);
  localparam int BeW      = DataWidth / 8;

  logic [NrHosts-1:0]      gnt_p0;
  logic [HostSelW-1:0]     host_sel_p0;
  logic                    req_p0;
  logic                    we_p0;
  logic [AddressWidth-1:0] addr_p0;
  logic [BeW-1:0]          be_p0;
  logic [DataWidth-1:0]    wdata_p0;
  logic [DevSelW-1:0]      dev_sel_p0;
  logic                    matched_p0;
  logic                    unmapped_p0;

  logic                    vld_p1;
  logic [HostSelW-1:0]     host_p1;
  logic [DevSelW-1:0]      dev_p1;
  logic                    unmapped_p1;

  logic                    dev_rvalid;
  logic                    dev_err;
  logic [DataWidth-1:0]    dev_rdata;
  logic                    rsp_valid;
  logic                    rsp_err;
  logic [DataWidth-1:0]    rsp_rdata;

  bus_arbiter #(.NrHosts(NrHosts)) u_arbiter (
    .req (bus.host_req_i),
    .gnt (gnt_p0),
    .idx (host_sel_p0),
    .any (req_p0)
  );

  assign bus.host_gnt_o = gnt_p0;

  // Pick the winning host's request fields through its one-hot grant.
  always_comb begin
    we_p0    = 1'b0;
    addr_p0  = '0;
    be_p0    = '0;
    wdata_p0 = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (gnt_p0[h]) begin
        we_p0    = bus.host_we_i[h];
        addr_p0  = bus.host_addr_i[h];
        be_p0    = bus.host_be_i[h];
        wdata_p0 = bus.host_wdata_i[h];
      end
    end
  end

  // Address decode: lowest matching device index wins; no match leaves device 0 selected.
  always_comb begin
    dev_sel_p0 = '0;
    matched_p0 = 1'b0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((addr_p0 & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        dev_sel_p0 = DevSelW'(d);
        matched_p0 = 1'b1;
      end
    end
  end

`ifdef BUS_DECODE_ERR_EN
  assign unmapped_p0 = ~matched_p0;
`else
  logic unused_matched;
  assign unused_matched = matched_p0;
  assign unmapped_p0    = 1'b0;
`endif

  // Raise req only on the selected device; all devices see the winner's fields.
  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      bus.device_req_o[d] = req_p0 && !unmapped_p0 && (dev_sel_p0 == DevSelW'(d));
    end
  end

  assign bus.device_we_o    = {NrDevices{we_p0}};
  assign bus.device_addr_o  = {NrDevices{addr_p0}};
  assign bus.device_be_o    = {NrDevices{be_p0}};
  assign bus.device_wdata_o = {NrDevices{wdata_p0}};

  // ---- p0 -> p1: remember who was granted and where the request went ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1      <= RESP_VLD_RST;
      host_p1     <= HostSelW'(RESP_HOST_RST);
      dev_p1      <= DevSelW'(RESP_DEV_RST);
      unmapped_p1 <= RESP_UNMAPPED_RST;
    end else begin
      vld_p1 <= req_p0;
      if (req_p0) begin
        host_p1     <= host_sel_p0;
        dev_p1      <= dev_sel_p0;
        unmapped_p1 <= unmapped_p0;
      end
    end
  end

  // Select the registered device's response; unmapped accesses answer with an error.
  always_comb begin
    dev_rvalid = 1'b0;
    dev_err    = 1'b0;
    dev_rdata  = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (dev_p1 == DevSelW'(d)) begin
        dev_rvalid = bus.device_rvalid_i[d];
        dev_err    = bus.device_err_i[d];
        dev_rdata  = bus.device_rdata_i[d];
      end
    end
    rsp_valid = vld_p1 && (unmapped_p1 || dev_rvalid);
    rsp_err   = vld_p1 && (unmapped_p1 || dev_err);
    rsp_rdata = (vld_p1 && !unmapped_p1) ? dev_rdata : '0;
  end

  // Steer the response to the registered host only; every other host sees zeros.
  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      if (host_p1 == HostSelW'(h)) begin
        bus.host_rvalid_o[h] = rsp_valid;
        bus.host_err_o[h]    = rsp_err;
        bus.host_rdata_o[h]  = rsp_rdata;
      end else begin
        bus.host_rvalid_o[h] = 1'b0;
        bus.host_err_o[h]    = 1'b0;
        bus.host_rdata_o[h]  = '0;
      end
    end
  end

endmodule

// File: tb/tb_simple_bus.sv
// Self-checking bench for simple_bus: 2 hosts, 3 devices (Ram, SimCtrl, Timer).
// Honours BUS_DECODE_ERR_EN when compiled with the same define as the RTL.
module tb_simple_bus;

`ifdef BUS_DECODE_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk;
  logic rst_ni;
  logic [2:0][31:0] cfg_base;
  logic [2:0][31:0] cfg_mask;

  simple_bus_if #(.NrHosts(2), .NrDevices(3), .DataWidth(32), .AddressWidth(32)) bus_if ();

  simple_bus #(.NrDevices(3), .NrHosts(2), .DataWidth(32), .AddressWidth(32)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_ni),
    .bus                  (bus_if),
    .cfg_device_addr_base (cfg_base),
    .cfg_device_addr_mask (cfg_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus for the next cycle.
  logic [1:0]       t_req;
  logic [1:0]       t_we;
  logic [1:0][31:0] t_addr;
  logic [1:0][3:0]  t_be;
  logic [1:0][31:0] t_wdata;

  // Expected response for the cycle after a grant.
  bit          pend_vld;
  int          pend_host;
  int          pend_dev;
  bit          pend_unm;
  bit          pend_err;
  logic [31:0] pend_rdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First window that contains the address, or -1 when none does.
  function automatic int decode(input logic [31:0] a);
    for (int d = 0; d < 3; d++)
      if ((a & cfg_mask[d]) == cfg_base[d]) return d;
    return -1;
  endfunction

  // Device behaviour: Ram holds 0xDEADBEEF at 0x100004, other reads echo a tagged address.
  function automatic logic [31:0] dev_rdata(input int d, input logic [31:0] a);
    if (d == 0 && a == 32'h0010_0004) return 32'hDEAD_BEEF;
    return a ^ (32'h5A5A_0000 + 32'(d));
  endfunction

  // Timer faults reads with address bit 3 set.
  function automatic bit dev_err(input int d, input logic [31:0] a, input logic we);
    return (d == 2) && !we && a[3];
  endfunction

  task automatic check_resp(input string tag);
    logic [1:0]  exp_rv;
    logic [1:0]  exp_er;
    logic [63:0] exp_rd;
    exp_rv = pend_vld ? (2'b01 << pend_host) : 2'b00;
    exp_er = (pend_vld && pend_err) ? (2'b01 << pend_host) : 2'b00;
    exp_rd = pend_vld ? (64'(pend_rdata) << (32 * pend_host)) : 64'd0;
    chk({tag, "_rvalid"}, 128'(bus_if.host_rvalid_o), 128'(exp_rv));
    chk({tag, "_err"},    128'(bus_if.host_err_o),    128'(exp_er));
    chk({tag, "_rdata"},  128'(bus_if.host_rdata_o),  128'(exp_rd));
  endtask

  task automatic drive_devices();
    for (int d = 0; d < 3; d++) begin
      bus_if.device_rvalid_i[d] = 1'b0;
      bus_if.device_err_i[d]    = 1'($urandom_range(0, 1));
      bus_if.device_rdata_i[d]  = $urandom;
    end
    if (pend_vld && !pend_unm) begin
      bus_if.device_rvalid_i[pend_dev] = 1'b1;
      bus_if.device_err_i[pend_dev]    = pend_err;
      bus_if.device_rdata_i[pend_dev]  = pend_rdata;
    end
  endtask

  // One bus cycle: check last response, apply t_*, check grant/forwarding, play devices.
  task automatic step(input string tag);
    int          w;
    int          dv;
    bit          unm;
    logic [31:0] a;
    logic [1:0]  exp_gnt;
    logic [2:0]  exp_dreq;
    @(negedge clk);
    check_resp(tag);
    bus_if.host_req_i   = t_req;
    bus_if.host_we_i    = t_we;
    bus_if.host_addr_i  = t_addr;
    bus_if.host_be_i    = t_be;
    bus_if.host_wdata_i = t_wdata;
    #1;
    w = t_req[0] ? 0 : (t_req[1] ? 1 : -1);
    exp_gnt = (w < 0) ? 2'b00 : (2'b01 << w);
    chk({tag, "_gnt"}, 128'(bus_if.host_gnt_o), 128'(exp_gnt));
    if (w < 0) begin
      chk({tag, "_dreq_idle"}, 128'(bus_if.device_req_o), 128'd0);
      pend_vld = 1'b0;
    end else begin
      a   = t_addr[w];
      dv  = decode(a);
      unm = (dv < 0);
      if (unm) dv = 0;
      exp_dreq = (unm && ErrEn) ? 3'b000 : (3'b001 << dv);
      chk({tag, "_dreq"},  128'(bus_if.device_req_o),   128'(exp_dreq));
      chk({tag, "_daddr"}, 128'(bus_if.device_addr_o),  128'({3{a}}));
      chk({tag, "_dwe"},   128'(bus_if.device_we_o),    128'({3{t_we[w]}}));
      chk({tag, "_dbe"},   128'(bus_if.device_be_o),    128'({3{t_be[w]}}));
      chk({tag, "_dwdat"}, 128'(bus_if.device_wdata_o), 128'({3{t_wdata[w]}}));
      pend_vld   = 1'b1;
      pend_host  = w;
      pend_dev   = dv;
      pend_unm   = unm && ErrEn;
      pend_err   = pend_unm ? 1'b1 : dev_err(dv, a, t_we[w]);
      pend_rdata = pend_unm ? 32'd0 : dev_rdata(dv, a);
    end
    @(posedge clk);
    #1;
    drive_devices();
  endtask

  task automatic set_host(input int h, input logic we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
    t_req[h]   = 1'b1;
    t_we[h]    = we;
    t_addr[h]  = a;
    t_be[h]    = be;
    t_wdata[h] = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h0010_0000 | ($urandom & 32'h000F_FFFF);
      1:       return 32'h0002_0000 | ($urandom & 32'h0000_03FF);
      2:       return 32'h0003_0000 | ($urandom & 32'h0000_03FF);
      default: return 32'h0005_0000 | ($urandom & 32'h0000_FFFF);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
    t_req = '0; t_we = '0; t_addr = '0; t_be = '0; t_wdata = '0;
    bus_if.host_req_i = '0; bus_if.host_we_i = '0; bus_if.host_addr_i = '0;
    bus_if.host_be_i = '0; bus_if.host_wdata_i = '0;
    bus_if.device_rvalid_i = '0; bus_if.device_err_i = '0; bus_if.device_rdata_i = '0;
    pend_vld = 1'b0; pend_host = 0; pend_dev = 0; pend_unm = 1'b0; pend_err = 1'b0;
    pend_rdata = '0;

    // Power-on reset.
    rst_ni = 1'b0;
    #1;
    chk("rst_rvalid", 128'(bus_if.host_rvalid_o), 128'd0);
    chk("rst_err",    128'(bus_if.host_err_o),    128'd0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rel_rvalid", 128'(bus_if.host_rvalid_o), 128'd0);

    step("idle0");

    // Host0 reads Ram.
    t_req = '0; set_host(0, 1'b0, 32'h0010_0004, 4'hF, 32'h0);
    step("ram_rd");
    // Host0 writes SimCtrl.
    t_req = '0; set_host(0, 1'b1, 32'h0002_0000, 4'hF, 32'h41);
    step("sim_wr");
    // Both hosts contend; host1 holds and wins next.
    t_req = '0;
    set_host(0, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
    set_host(1, 1'b1, 32'h0003_0004, 4'h3, 32'h1234_5678);
    step("both");
    t_req = '0; set_host(1, 1'b1, 32'h0003_0004, 4'h3, 32'h1234_5678);
    step("h1_hold");
    // Timer error read.
    t_req = '0; set_host(0, 1'b0, 32'h0003_0008, 4'hF, 32'h0);
    step("tmr_err");
    // Unmapped access.
    t_req = '0; set_host(1, 1'b0, 32'h0005_0000, 4'hF, 32'h0);
    step("unmapped");
    t_req = '0;
    step("idle1");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      t_req = 2'($urandom_range(0, 3));
      for (int h = 0; h < 2; h++) begin
        t_we[h]    = 1'($urandom_range(0, 1));
        t_addr[h]  = rand_addr();
        t_be[h]    = 4'($urandom_range(0, 15));
        t_wdata[h] = $urandom;
      end
      step("rand");
    end

    // Reset in the cycle after a grant drops the response.
    t_req = '0; set_host(0, 1'b0, 32'h0010_0004, 4'hF, 32'h0);
    step("pre_rst");
    rst_ni = 1'b0;
    t_req = '0;
    bus_if.host_req_i = '0;
    #1;
    chk("midrst_rvalid", 128'(bus_if.host_rvalid_o), 128'd0);
    chk("midrst_err",    128'(bus_if.host_err_o),    128'd0);
    repeat (2) begin
      @(negedge clk);
      chk("inrst_rvalid", 128'(bus_if.host_rvalid_o), 128'd0);
    end
    rst_ni = 1'b1;
    pend_vld = 1'b0;
    #1;
    chk("postrst_rvalid", 128'(bus_if.host_rvalid_o), 128'd0);
    chk("postrst_err",    128'(bus_if.host_err_o),    128'd0);
    step("post_rst");
    t_req = '0; set_host(1, 1'b0, 32'h0002_0100, 4'hF, 32'h0);
    step("post_rd");
    t_req = '0;
    step("tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
